// File: rtl/sobel_edge_core.sv
// Streaming 3x3 Sobel edge detector for single-channel grey video.
// Internal line buffers, frame-aligned config capture, binary or saturated-magnitude output.
module sobel_edge_core #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IMG_W  = 200,
    parameter int unsigned IMG_H  = 200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pi_flag,
    input  logic [DATA_W-1:0] pi_data,
    input  logic [DATA_W+2:0] cfg_thresh,
    input  logic              cfg_mode,
    output logic              po_flag,
    output logic [DATA_W-1:0] po_data,
    output logic              po_eof
);

    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned G_W   = DATA_W + 3;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [G_W-1:0]   PIX_MAX  = {3'b000, {DATA_W{1'b1}}};

    // ------------------------------------------------------------------
    // Input raster counters and config capture
    // ------------------------------------------------------------------
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [G_W-1:0]   thresh_q, thresh_sel;
    logic             mode_q, mode_sel;
    logic             accept;
    logic             frame_start;
    logic             win_ok;
    logic             last_px;

    assign accept      = pi_flag & ~rst;
    assign frame_start = (col_q == '0) && (row_q == '0);
    assign win_ok      = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
    assign last_px     = (row_q == ROW_LAST) && (col_q == COL_LAST);

    // The first pixel of a frame sees the live config; later pixels see the captured copy.
    assign thresh_sel  = frame_start ? cfg_thresh : thresh_q;
    assign mode_sel    = frame_start ? cfg_mode : mode_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pi_flag) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q    <= '0;
            row_q    <= '0;
            thresh_q <= '0;
            mode_q   <= 1'b0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (pi_flag && frame_start) begin
                thresh_q <= cfg_thresh;
                mode_q   <= cfg_mode;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: lb0 holds the previous line, lb1 the one before it
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] rd_top_q, rd_mid_q, rd_bot_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            lb0[col_q] <= pi_data;
            lb1[col_q] <= lb0[col_q];
            rd_top_q   <= lb1[col_q];
            rd_mid_q   <= lb0[col_q];
            rd_bot_q   <= pi_data;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline control: valid, eof and frame config travel with each pixel
    // ------------------------------------------------------------------
    logic           shift_q;
    logic           v_rd_q, v_win_q, v_grad_q, v_mag_q;
    logic           e_rd_q, e_win_q, e_grad_q, e_mag_q;
    logic [G_W-1:0] t_rd_q, t_win_q, t_grad_q, t_mag_q;
    logic           m_rd_q, m_win_q, m_grad_q, m_mag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q  <= 1'b0;
            v_rd_q   <= 1'b0;
            v_win_q  <= 1'b0;
            v_grad_q <= 1'b0;
            v_mag_q  <= 1'b0;
            e_rd_q   <= 1'b0;
            e_win_q  <= 1'b0;
            e_grad_q <= 1'b0;
            e_mag_q  <= 1'b0;
        end else begin
            shift_q  <= pi_flag;
            v_rd_q   <= pi_flag & win_ok;
            e_rd_q   <= pi_flag & last_px;
            v_win_q  <= v_rd_q;
            e_win_q  <= e_rd_q;
            v_grad_q <= v_win_q;
            e_grad_q <= e_win_q;
            v_mag_q  <= v_grad_q;
            e_mag_q  <= e_grad_q;
        end
    end

    always_ff @(posedge clk) begin
        t_rd_q   <= thresh_sel;
        m_rd_q   <= mode_sel;
        t_win_q  <= t_rd_q;
        m_win_q  <= m_rd_q;
        t_grad_q <= t_win_q;
        m_grad_q <= m_win_q;
        t_mag_q  <= t_grad_q;
        m_mag_q  <= m_grad_q;
    end

    // ------------------------------------------------------------------
    // 3x3 window, [row][col] with row 0 = top and col 2 = newest
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] win_q [3][3];

    always_ff @(posedge clk) begin
        if (shift_q) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= rd_top_q;
            win_q[1][2] <= rd_mid_q;
            win_q[2][2] <= rd_bot_q;
        end
    end

    // ------------------------------------------------------------------
    // Gradients; each weighted sum is at most 4*(2^DATA_W-1), so G_W bits suffice
    // ------------------------------------------------------------------
    function automatic logic [G_W-1:0] ext(input logic [DATA_W-1:0] p);
        return G_W'(p);
    endfunction

    logic [G_W-1:0]        gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [G_W-1:0] gx_q, gy_q;

    always_comb begin
        gx_pos = ext(win_q[0][2]) + (ext(win_q[1][2]) << 1) + ext(win_q[2][2]);
        gx_neg = ext(win_q[0][0]) + (ext(win_q[1][0]) << 1) + ext(win_q[2][0]);
        gy_pos = ext(win_q[2][0]) + (ext(win_q[2][1]) << 1) + ext(win_q[2][2]);
        gy_neg = ext(win_q[0][0]) + (ext(win_q[0][1]) << 1) + ext(win_q[0][2]);
    end

    always_ff @(posedge clk) begin
        gx_q <= signed'(gx_pos - gx_neg);
        gy_q <= signed'(gy_pos - gy_neg);
    end

    // ------------------------------------------------------------------
    // Magnitude |Gx| + |Gy|; the maximum 8*(2^DATA_W-1) cannot wrap
    // ------------------------------------------------------------------
    logic [G_W-1:0] gx_abs, gy_abs, mag_q;

    always_comb begin
        gx_abs = gx_q[G_W-1] ? (~gx_q + G_W'(1)) : gx_q;
        gy_abs = gy_q[G_W-1] ? (~gy_q + G_W'(1)) : gy_q;
    end

    always_ff @(posedge clk) begin
        mag_q <= gx_abs + gy_abs;
    end

    // ------------------------------------------------------------------
    // Output mapping and register
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] map_data;

    always_comb begin
        map_data = '0;
        if (m_mag_q) begin
            map_data = (mag_q > PIX_MAX) ? {DATA_W{1'b1}} : mag_q[DATA_W-1:0];
        end else if (mag_q > t_mag_q) begin
            map_data = {DATA_W{1'b1}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            po_flag <= 1'b0;
            po_eof  <= 1'b0;
            po_data <= '0;
        end else begin
            po_flag <= v_mag_q;
            po_eof  <= v_mag_q & e_mag_q;
            if (v_mag_q) begin
                po_data <= map_data;
            end
        end
    end

endmodule

// File: tb/tb_sobel_edge_core.sv
// Self-checking bench for sobel_edge_core on an 8x8 frame: vector table plus
// hand-written back-to-back config and mid-frame reset sequences, scoreboard-checked.
module tb_sobel_edge_core;

    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int NOUT = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          pi_flag;
    logic [DW-1:0] pi_data;
    logic [DW+2:0] cfg_thresh;
    logic          cfg_mode;
    logic          po_flag;
    logic [DW-1:0] po_data;
    logic          po_eof;

    always #5 clk = ~clk;

    sobel_edge_core #(
        .DATA_W(DW),
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pi_flag   (pi_flag),
        .pi_data   (pi_data),
        .cfg_thresh(cfg_thresh),
        .cfg_mode  (cfg_mode),
        .po_flag   (po_flag),
        .po_data   (po_data),
        .po_eof    (po_eof)
    );

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic          eof;
    } exp_t;

    typedef struct {
        int pat;
        bit mode;
        int thresh;
        int duty;
        int n_ff;
        int n_zero;
    } vec_t;

    exp_t          sb[$];
    exp_t          mon_e;
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            img[H][W];
    bit            mon_en = 1'b0;
    logic [DW-1:0] last_data = '0;
    int            cnt_out, cnt_ff, cnt_zero, cnt_other, cnt_eof;
    bit            m_mode;
    int            m_thresh;
    vec_t          tbl[9];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference Sobel on the bench's own image copy, using the config captured at (0,0).
    function automatic logic [DW-1:0] model(input int r, input int c);
        int gx, gy, mag;
        gx = (img[r-2][c] + 2 * img[r-1][c] + img[r][c])
           - (img[r-2][c-2] + 2 * img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2 * img[r][c-1] + img[r][c])
           - (img[r-2][c-2] + 2 * img[r-2][c-1] + img[r-2][c]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        mag = gx + gy;
        if (m_mode) return (mag > 255) ? 8'hFF : 8'(mag);
        return (mag > m_thresh) ? 8'hFF : 8'h00;
    endfunction

    // Monitor: every cycle either the scheduled output appears or the outputs are idle.
    always begin
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (po_flag === 1'b1) begin
                cnt_out++;
                if (po_data == 8'hFF) cnt_ff++;
                else if (po_data == 8'h00) cnt_zero++;
                else cnt_other++;
                if (po_eof === 1'b1) cnt_eof++;
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_e = sb.pop_front();
                chk("po_flag", 32'(po_flag), 32'd1);
                chk("po_data", 32'(po_data), 32'(mon_e.data));
                chk("po_eof", 32'(po_eof), 32'(mon_e.eof));
                last_data = mon_e.data;
            end else begin
                chk("po_flag idle", 32'(po_flag), 32'd0);
                chk("po_eof idle", 32'(po_eof), 32'd0);
                chk("po_data hold", 32'(po_data), 32'(last_data));
            end
        end
    end

    task automatic idle();
        @(negedge clk);
        pi_flag = 1'b0;
        pi_data = 8'($urandom);
    endtask

    task automatic push_pixel(input int r, input int c);
        exp_t e;
        @(negedge clk);
        pi_flag = 1'b1;
        pi_data = 8'(img[r][c]);
        if (r == 0 && c == 0) begin
            m_mode   = cfg_mode;
            m_thresh = int'(cfg_thresh);
        end
        if (r >= 2 && c >= 2) begin
            e.due  = cyc + 5;
            e.data = model(r, c);
            e.eof  = (r == H - 1) && (c == W - 1);
            sb.push_back(e);
        end
    endtask

    task automatic send_frame(input int duty, input int npix, input bit chg, input bit mode_mid);
        int r, c;
        for (int i = 0; i < npix; i++) begin
            r = i / W;
            c = i % W;
            if (chg && r == 5) cfg_mode = mode_mid;
            while ($urandom_range(99) >= duty) idle();
            push_pixel(r, c);
        end
    endtask

    task automatic drain();
        idle();
        for (int k = 0; k < 20 && sb.size() != 0; k++) idle();
        repeat (3) idle();
        chk("drain pending", 32'(sb.size()), 32'd0);
    endtask

    task automatic set_image(input int pat);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                case (pat)
                    0: img[r][c] = 37;
                    1: img[r][c] = (c < 4) ? 0 : 100;
                    2: img[r][c] = 10 * r;
                    default: img[r][c] = int'($urandom_range(255));
                endcase
            end
        end
    endtask

    task automatic clear_counts();
        cnt_out = 0;
        cnt_ff = 0;
        cnt_zero = 0;
        cnt_other = 0;
        cnt_eof = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        // pat, mode, thresh, duty%, expected 0xFF count, expected 0x00 count (-1 = unchecked)
        tbl[0] = '{0, 1'b0, 12,  100, 0,  36};
        tbl[1] = '{1, 1'b1, 0,   100, 12, 24};
        tbl[2] = '{1, 1'b0, 400, 100, 0,  36};
        tbl[3] = '{1, 1'b0, 399, 100, 12, 24};
        tbl[4] = '{2, 1'b1, 0,   100, 0,  0};
        tbl[5] = '{2, 1'b1, 0,   30,  0,  0};
        tbl[6] = '{1, 1'b1, 0,   30,  12, 24};
        tbl[7] = '{3, 1'b1, 0,   30,  -1, -1};
        tbl[8] = '{3, 1'b0, 300, 100, -1, -1};

        rst = 1'b1;
        pi_flag = 1'b0;
        pi_data = '0;
        cfg_thresh = '0;
        cfg_mode = 1'b0;
        clear_counts();
        repeat (3) @(posedge clk);
        #1;
        chk("reset po_flag", 32'(po_flag), 32'd0);
        chk("reset po_data", 32'(po_data), 32'd0);
        chk("reset po_eof", 32'(po_eof), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        last_data = '0;
        mon_en = 1'b1;

        for (int i = 0; i < 9; i++) begin
            set_image(tbl[i].pat);
            cfg_mode = tbl[i].mode;
            cfg_thresh = 11'(tbl[i].thresh);
            clear_counts();
            send_frame(tbl[i].duty, W * H, 1'b0, 1'b0);
            drain();
            chk($sformatf("vec%0d outputs", i), 32'(cnt_out), 32'(NOUT));
            chk($sformatf("vec%0d eof count", i), 32'(cnt_eof), 32'd1);
            if (tbl[i].n_ff >= 0) begin
                chk($sformatf("vec%0d ff count", i), 32'(cnt_ff), 32'(tbl[i].n_ff));
                chk($sformatf("vec%0d zero count", i), 32'(cnt_zero), 32'(tbl[i].n_zero));
            end
        end

        // Back-to-back frames, mode switched 0 -> 1 at row 5 of the first frame.
        set_image(2);
        cfg_mode = 1'b0;
        cfg_thresh = 11'd50;
        clear_counts();
        send_frame(100, W * H, 1'b1, 1'b1);
        send_frame(100, W * H, 1'b0, 1'b0);
        drain();
        chk("cfg outputs", 32'(cnt_out), 32'(2 * NOUT));
        chk("cfg binary frame", 32'(cnt_ff), 32'(NOUT));
        chk("cfg magnitude frame", 32'(cnt_other), 32'(NOUT));
        chk("cfg eof count", 32'(cnt_eof), 32'd2);

        // Reset at row 4, col 3 with a pixel presented at the same edge.
        set_image(3);
        cfg_mode = 1'b1;
        cfg_thresh = 11'd0;
        send_frame(100, 4 * W + 3, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        pi_flag = 1'b1;
        pi_data = 8'hA5;
        sb.delete();
        last_data = '0;
        @(negedge clk);
        rst = 1'b0;
        pi_flag = 1'b0;
        clear_counts();
        repeat (6) idle();
        chk("post-reset residual outputs", 32'(cnt_out), 32'd0);
        set_image(3);
        cfg_mode = 1'b1;
        send_frame(100, W * H, 1'b0, 1'b0);
        drain();
        chk("post-reset outputs", 32'(cnt_out), 32'(NOUT));
        chk("post-reset eof count", 32'(cnt_eof), 32'd1);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sobel_edge_core.md
Name: sobel_edge_core

Overview:
- Parametrised successor to the current fixed-size 8-bit Sobel stage: streaming 3x3 Sobel edge detector for single-channel grey video.
- Internal line buffers (no external FIFO IP), configurable pixel width and frame size, runtime threshold, and selectable binary or magnitude output.
- Sits between the pixel source (UART or camera grey stream) and the frame sink.
- Adds an end-of-frame marker and frame-aligned configuration capture.

Parameters:
- DATA_W, 8: pixel width in bits.
- IMG_W, 200: pixels per line. Minimum 4.
- IMG_H, 200: lines per frame. Minimum 3.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- pi_flag  in  1  input pixel valid. Raster order. Arbitrary gaps allowed.
- pi_data  in  DATA_W  input pixel, unsigned.
- cfg_thresh  in  DATA_W+3  edge threshold, unsigned.
- cfg_mode  in  1  0 = binary edge map, 1 = saturated gradient magnitude.
- po_flag  out  1  output pixel valid.
- po_data  out  DATA_W  output pixel.
- po_eof  out  1  high together with po_flag on the last output pixel of a frame.

Behaviour:
- Reset (rst high at a clk edge):
  - po_flag = 0, po_data = 0, po_eof = 0.
  - Column and row counters = 0. All pipeline valid bits cleared.
  - Line-buffer contents are don't-care.
  - Reset mid-frame abandons the frame. The next accepted pixel is treated as row 0, column 0.
- Input counters:
  - col increments on each pi_flag and wraps IMG_W-1 -> 0.
  - row increments on col wrap and wraps IMG_H-1 -> 0.
  - Counter widths are clog2 of the respective dimension.
- Config capture:
  - cfg_thresh and cfg_mode are registered when the pixel at row 0, col 0 is accepted.
  - The captured values hold for the whole frame. Changes mid-frame take effect at the next frame.
- Line buffers:
  - Two single-port-per-side RAMs of depth IMG_W, addressed by col.
  - On each accepted pixel: read lb0[col] and lb1[col], write lb0[col] <= pi_data and lb1[col] <= old lb0[col].
  - Read-before-write at the same address. No full/empty state exists.
- Window:
  - 3x3 registers shift left only on accepted pixels.
  - Rows are top = lb1 output (row-2), mid = lb0 output (row-1), bottom = pi_data (row).
  - Right column is newest. Gaps in pi_flag freeze the window.
- Window validity:
  - A window is valid when the accepted pixel has row >= 2 and col >= 2.
  - It is centred on (row-1, col-1).
  - This gives (IMG_W-2)*(IMG_H-2) outputs per frame. Border pixels produce no output.
- Gradients, signed, width DATA_W+3:
  - Gx = (TR + 2MR + BR) - (TL + 2ML + BL)
  - Gy = (BL + 2BC + BR) - (TL + 2TC + TR)
- Magnitude:
  - mag = |Gx| + |Gy|, unsigned, width DATA_W+3.
  - No wrap possible: the maximum is 8*(2^DATA_W - 1).
- Output mapping:
  - Mode 0: po_data = all ones if mag > thresh, else 0.
  - Mode 1: po_data = mag saturated to 2^DATA_W - 1.
- Pipeline, fixed latency of 4 clk cycles from the accepting edge to po_flag:
  - Stage 1: RAM read / window shift.
  - Stage 2: Gx, Gy.
  - Stage 3: abs and sum.
  - Stage 4: map and register.
- Valid propagation:
  - Valid propagates every cycle, independent of later pi_flag gaps.
  - Outputs are never dropped and never duplicated.
  - po_flag is low whenever there is no output. po_data holds its last value.
- po_eof asserts for exactly one cycle, with the output whose source pixel is at row IMG_H-1, col IMG_W-1.
- Back-to-back frames:
  - The pixel at row 0, col 0 of the next frame may arrive the cycle after the last pixel of the current frame.
  - Rows 0 and 1 of the new frame refill the line buffers. No outputs are produced from stale rows.
- Simultaneous reset and pi_flag: reset wins and the pixel is discarded.

Test Plan:
- Flat frame (IMG_W=IMG_H=8, all pixels 37), mode 0, thresh 12 -> 36 outputs, all 0x00.
  - The first po_flag comes 4 cycles after accepting row 2, col 2.
  - po_eof on the 36th output only.
- Vertical step (IMG_W=IMG_H=8, cols 0-3 = 0, cols 4-7 = 100), mode 1:
  - Output centre cols 3 and 4 -> mag 400, saturated to 0xFF.
  - All other outputs -> 0x00.
  - In mode 0 with thresh 400 these are all 0x00. With thresh 399 the centre cols 3 and 4 are 0xFF.
- Horizontal ramp (pixel = 10*row), mode 1 -> every output = 80 (|Gy| = 4*20, Gx = 0).
- Random gaps: pi_flag random at 30% duty -> output sequence identical to the gap-free run.
  - Each po_flag occurs exactly 4 cycles after its source pixel.
- Config timing: change cfg_mode from 0 to 1 at row 5 of frame 1 -> frame 1 stays binary, frame 2 outputs magnitude.
  - Frames run back-to-back with no idle cycle.
- Reset mid-frame: assert rst for 1 cycle at row 4, col 3 -> po_flag = 0 from the next cycle.
  - No residual outputs.
  - A following full frame produces exactly (IMG_W-2)*(IMG_H-2) correct outputs.
